// File: rtl/punc_control.sv
// punc_control: multi-cycle instruction-sequencing FSM for the PUNC datapath.
// The optional single-step feature is enabled by defining PUNC_STEP_EN. When
// it is defined, the design adds a step port and a WAIT state after every
// retired instruction.
module punc_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instruction,
`ifdef PUNC_STEP_EN
    input  logic        step,
`endif
    output logic [4:0]  state,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] retired
);

    typedef enum logic [4:0] {
        StFetch  = 5'd0,  StDecode = 5'd1,  StAddR  = 5'd2,  StAddI  = 5'd3,
        StAndR   = 5'd4,  StAndI   = 5'd5,  StBr    = 5'd6,  StJmp   = 5'd7,
        StJsr1   = 5'd8,  StJsr2   = 5'd9,  StJsrr1 = 5'd10, StJsrr2 = 5'd11,
        StLd     = 5'd12, StLdi1   = 5'd13, StLdi2  = 5'd14, StLdr   = 5'd15,
        StLea    = 5'd16, StNot    = 5'd17, StRet   = 5'd18, StSt    = 5'd19,
        StSti1   = 5'd20, StSti2   = 5'd21, StStr   = 5'd22, StHalt  = 5'd23,
        StWait   = 5'd24
    } state_e;

    // Destination after the last exec state of an instruction
`ifdef PUNC_STEP_EN
    localparam state_e TermNext = StWait;
`else
    localparam state_e TermNext = StFetch;
`endif

    state_e      state_q, state_d;
    logic        illegal_q, illegal_d;
    logic [15:0] retired_q, retired_d;
    logic        retire;
    logic        set_illegal;

    // Only opcode and a few mode bits steer the sequencer
    logic unused_instr;
    assign unused_instr = ^{instruction[10:9], instruction[4:0]};

    // Next-state decode and retire/illegal event generation
    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        set_illegal = 1'b0;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                unique case (instruction[15:12])
                    4'b0001: state_d = instruction[5] ? StAddI : StAddR;
                    4'b0101: state_d = instruction[5] ? StAndI : StAndR;
                    4'b0000: state_d = StBr;
                    4'b1100: state_d = (instruction[8:6] == 3'b111) ? StRet : StJmp;
                    4'b0100: state_d = instruction[11] ? StJsr1 : StJsrr1;
                    4'b0010: state_d = StLd;
                    4'b1010: state_d = StLdi1;
                    4'b0110: state_d = StLdr;
                    4'b1110: state_d = StLea;
                    4'b1001: state_d = StNot;
                    4'b0011: state_d = StSt;
                    4'b1011: state_d = StSti1;
                    4'b0111: state_d = StStr;
                    4'b1111: state_d = StHalt;
                    4'b1000, 4'b1101: begin
                        state_d     = StHalt;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            StJsr1:  state_d = StJsr2;
            StJsrr1: state_d = StJsrr2;
            StLdi1:  state_d = StLdi2;
            StSti1:  state_d = StSti2;
            StAddR, StAddI, StAndR, StAndI, StBr, StJmp, StJsr2, StJsrr2, StLd,
            StLdi2, StLdr, StLea, StNot, StRet, StSt, StSti2, StStr: begin
                state_d = TermNext;
                retire  = 1'b1;
            end
            StHalt:  state_d = StHalt;
`ifdef PUNC_STEP_EN
            StWait:  state_d = step ? StFetch : StWait;
`endif
            // Codes 25-31 (and WAIT when stepping is compiled out) recover to FETCH
            default: state_d = StFetch;
        endcase
    end

    // Sticky illegal flag and saturating retire counter
    always_comb begin
        illegal_d = illegal_q | set_illegal;
        retired_d = retired_q;
        if (retire && (retired_q != 16'hFFFF)) begin
            retired_d = retired_q + 16'd1;
        end
    end

    // State registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
            retired_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign halted  = (state_q == StHalt);
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_punc_control.sv
// Scoreboard bench for punc_control: stimulus pushes expected post-edge values,
// a negedge monitor pops and compares them. Handles both PUNC_STEP_EN builds.
module tb_punc_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instruction;
`ifdef PUNC_STEP_EN
    logic        step;
    localparam int AfterTerm = 24;
`else
    localparam int AfterTerm = 0;
`endif
    logic [4:0]  state;
    logic        halted;
    logic        illegal;
    logic [15:0] retired;

    typedef struct {
        logic [4:0]  st;
        logic        h;
        logic        il;
        logic [15:0] rt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic        m_ill = 1'b0;
    logic [15:0] m_ret = 16'd0;

    always #5 clk = ~clk;

    punc_control dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
`ifdef PUNC_STEP_EN
        .step        (step),
`endif
        .state       (state),
        .halted      (halted),
        .illegal     (illegal),
        .retired     (retired)
    );

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expected entry per clock edge, checked half a cycle later
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("state",   int'(state),   int'(e.st));
            check("halted",  int'(halted),  int'(e.h));
            check("illegal", int'(illegal), int'(e.il));
            check("retired", int'(retired), int'(e.rt));
        end
    end

    // Drive one edge worth of inputs and queue the expected result of that edge
    task automatic cyc(input logic r, input logic [15:0] ins, input int es);
        exp_t e;
        rst         = r;
        instruction = ins;
        e.st = 5'(es);
        e.h  = (es == 23);
        e.il = m_ill;
        e.rt = m_ret;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Full instruction from FETCH: DECODE, exec state(s), then back to FETCH/WAIT
    task automatic do_instr(input logic [15:0] ins, input int s1, input int s2);
        cyc(1'b0, ins, 1);
        cyc(1'b0, ins, s1);
        if (s2 >= 0) cyc(1'b0, ins, s2);
        m_ret = m_ret + 16'd1;
        cyc(1'b0, ins, AfterTerm);
`ifdef PUNC_STEP_EN
        step = 1'b1;
        cyc(1'b0, ins, 0);
        step = 1'b0;
`endif
    endtask

    initial begin
`ifdef PUNC_STEP_EN
        step = 1'b0;
`endif
        rst = 1'b1;
        instruction = 16'h0000;
        cyc(1'b1, 16'h0000, 0);

        do_instr(16'h1042, 2, -1);   // ADD_R
        do_instr(16'hA002, 13, 14);  // LDI
        do_instr(16'hC1C0, 18, -1);  // RET
        do_instr(16'h4801, 8, 9);    // JSR
        do_instr(16'h4000, 10, 11);  // JSRR
        do_instr(16'h5020, 5, -1);   // AND_I
        do_instr(16'h0E00, 6, -1);   // BR
        do_instr(16'hC080, 7, -1);   // JMP
        do_instr(16'h903F, 17, -1);  // NOT

        // Reset in the middle of STI
        cyc(1'b0, 16'hB000, 1);
        cyc(1'b0, 16'hB000, 20);
        m_ret = 16'd0;
        cyc(1'b1, 16'hB000, 0);
        do_instr(16'h7000, 22, -1);  // STR

        // HALT holds regardless of instruction
        cyc(1'b0, 16'hF000, 1);
        cyc(1'b0, 16'hF000, 23);
        for (int i = 0; i < 10; i++) cyc(1'b0, 16'h1042 + 16'(i * 4097), 23);
        m_ret = 16'd0;
        cyc(1'b1, 16'h0000, 0);

        // Illegal opcodes 1000 and 1101
        cyc(1'b0, 16'h8000, 1);
        m_ill = 1'b1;
        cyc(1'b0, 16'h8000, 23);
        cyc(1'b0, 16'h1042, 23);
        m_ill = 1'b0;
        cyc(1'b1, 16'h0000, 0);
        cyc(1'b0, 16'hD000, 1);
        m_ill = 1'b1;
        cyc(1'b0, 16'hD000, 23);
        m_ill = 1'b0;
        cyc(1'b1, 16'h0000, 0);

`ifdef PUNC_STEP_EN
        // Step ignored outside WAIT; WAIT holds until step
        step = 1'b1;
        cyc(1'b0, 16'h903F, 1);
        step = 1'b0;
        cyc(1'b0, 16'h903F, 17);
        m_ret = m_ret + 16'd1;
        cyc(1'b0, 16'h903F, 24);
        for (int i = 0; i < 5; i++) cyc(1'b0, 16'h903F, 24);
        step = 1'b1;
        cyc(1'b0, 16'h903F, 0);
        step = 1'b0;
`else
        do_instr(16'h903F, 17, -1);
`endif
        do_instr(16'h2000, 12, -1);  // LD

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        check("drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
